// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage pipelined floating-point adder/subtractor.
//
// The encoding is {sign, biased exponent, fraction}, with the exponent biased by
// 2^(EXP_W-1)-1. Denormal inputs count as signed zero. Results below the
// minimum normal are flushed to signed zero. Rounding is round-to-nearest-even.
//
// Ports:
//   clk        single clock; all state updates on the rising edge
//   rst_n      asynchronous assert, active-low reset
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle (combinational)
//   a, b       operands, W bits each
//   op         0 = a+b, 1 = a-b
//   out_valid  result beat present
//   out_ready  consumer accepts the result
//   result     rounded sum or difference
//   flags      {invalid, overflow, inexact}, aligned with result
//
// Handshake: a beat moves on a port only in a cycle where valid && ready are
// both high. valid is never withdrawn and payload never changes while
// valid && !ready. The pipeline has one global stall, stall = out_valid &&
// !out_ready. When stall is high every stage holds, and in_ready = !stall.
//
// Stages:
//   S1 unpack, compare and align
//   S2 add or subtract
//   S3 normalise, round and pack
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [2:0]   flags
);

  // Working mantissa: hidden bit, fraction, guard, round, sticky.
  localparam int FW = MAN_W + 4;
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // ---------------- S1: unpack / compare / align ----------------
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic [W-2:0]       mag_a, mag_b, mag_big, mag_small;
  logic               a_first;
  logic [FW-1:0]      big_ext, small_ext, small_al;
  logic [31:0]        diff;
  logic               s1_special, s1_invalid;
  logic [W-1:0]       s1_spec_val;

  assign sa = a[W-1];
  assign sb = b[W-1] ^ op;   // subtraction is addition of B with flipped sign
  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);
  assign a_snan = a_nan && !fa[MAN_W-1];
  assign b_snan = b_nan && !fb[MAN_W-1];

  // Denormals are forced to an all-zero magnitude so that they compare and
  // align exactly like zero.
  assign mag_a     = a_zero ? '0 : a[W-2:0];
  assign mag_b     = b_zero ? '0 : b[W-2:0];
  assign a_first   = (mag_a >= mag_b);
  assign mag_big   = a_first ? mag_a : mag_b;
  assign mag_small = a_first ? mag_b : mag_a;

  assign big_ext   = {(mag_big[W-2:MAN_W] != '0), mag_big[MAN_W-1:0], 3'b000};
  assign small_ext = {(mag_small[W-2:MAN_W] != '0), mag_small[MAN_W-1:0], 3'b000};
  assign diff      = 32'(mag_big[W-2:MAN_W]) - 32'(mag_small[W-2:MAN_W]);

  // A shift of FW-1 or more moves even the hidden bit past the sticky
  // position, so only a sticky bit survives.
  always_comb begin
    small_al = '0;
    if (diff >= 32'(FW - 1)) begin
      small_al = {{(FW-1){1'b0}}, |small_ext};
    end else begin
      small_al    = small_ext >> diff;
      small_al[0] = small_al[0] | (|(small_ext & ~({FW{1'b1}} << diff)));
    end
  end

  always_comb begin
    s1_special  = 1'b0;
    s1_invalid  = 1'b0;
    s1_spec_val = '0;
    if (a_nan || b_nan) begin
      s1_special  = 1'b1;
      s1_spec_val = QNAN;
      s1_invalid  = a_snan || b_snan;
    end else if (a_inf && b_inf && (sa != sb)) begin
      s1_special  = 1'b1;
      s1_spec_val = QNAN;
      s1_invalid  = 1'b1;
    end else if (a_inf) begin
      s1_special  = 1'b1;
      s1_spec_val = {sa, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      s1_special  = 1'b1;
      s1_spec_val = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end
  end

  logic             v1, sign_big1, sign_small1, spec1, inv1;
  logic [EXP_W-1:0] exp1;
  logic [FW-1:0]    man_big1, man_small1;
  logic [W-1:0]     spec_val1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      sign_big1   <= 1'b0;
      sign_small1 <= 1'b0;
      spec1       <= 1'b0;
      inv1        <= 1'b0;
      exp1        <= '0;
      man_big1    <= '0;
      man_small1  <= '0;
      spec_val1   <= '0;
    end else if (!stall) begin
      v1          <= in_valid;
      sign_big1   <= a_first ? sa : sb;
      sign_small1 <= a_first ? sb : sa;
      spec1       <= s1_special;
      inv1        <= s1_invalid;
      exp1        <= mag_big[W-2:MAN_W];
      man_big1    <= big_ext;
      man_small1  <= small_al;
      spec_val1   <= s1_spec_val;
    end
  end

  // ---------------- S2: add / subtract ----------------
  // The larger magnitude is always first, so the difference never goes negative.
  logic [FW:0] s2_sum;
  assign s2_sum = (sign_big1 != sign_small1) ? ({1'b0, man_big1} - {1'b0, man_small1})
                                             : ({1'b0, man_big1} + {1'b0, man_small1});

  logic             v2, sign2, zsign2, spec2, inv2;
  logic [EXP_W-1:0] exp2;
  logic [FW:0]      sum2;
  logic [W-1:0]     spec_val2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2        <= 1'b0;
      sign2     <= 1'b0;
      zsign2    <= 1'b0;
      spec2     <= 1'b0;
      inv2      <= 1'b0;
      exp2      <= '0;
      sum2      <= '0;
      spec_val2 <= '0;
    end else if (!stall) begin
      v2        <= v1;
      sign2     <= sign_big1;
      // An exact zero is negative only when both effective signs are negative.
      zsign2    <= sign_big1 & sign_small1;
      spec2     <= spec1;
      inv2      <= inv1;
      exp2      <= exp1;
      sum2      <= s2_sum;
      spec_val2 <= spec_val1;
    end
  end

  // ---------------- S3: normalise / round / pack ----------------
  logic [FW-1:0]    norm;
  logic [MAN_W+1:0] mant;
  logic [MAN_W-1:0] frac;
  logic             found, round_up, inexact;
  int               lz, exp_n, exp_r;
  logic [W-1:0]     res_c;
  logic [2:0]       flags_c;

  always_comb begin
    norm     = '0;
    lz       = 0;
    found    = 1'b0;
    exp_n    = 0;
    if (sum2[FW]) begin
      // A carry out needs a one-bit right shift. The bit shifted out folds
      // into sticky.
      norm    = sum2[FW:1];
      norm[0] = sum2[1] | sum2[0];
      exp_n   = int'(exp2) + 1;
    end else begin
      for (int i = FW - 1; i >= 0; i--) begin
        if (!found) begin
          if (sum2[i]) found = 1'b1;
          else         lz = lz + 1;
        end
      end
      norm  = sum2[FW-1:0] << lz;
      exp_n = int'(exp2) - lz;
    end

    inexact  = norm[2] | norm[1] | norm[0];
    round_up = norm[2] && (norm[1] || norm[0] || norm[3]);
    mant     = {1'b0, norm[FW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    exp_r    = exp_n;
    frac     = mant[MAN_W-1:0];
    if (mant[MAN_W+1]) begin
      exp_r = exp_n + 1;
      frac  = mant[MAN_W:1];
    end

    res_c   = '0;
    flags_c = '0;
    if (spec2) begin
      res_c   = spec_val2;
      flags_c = {inv2, 2'b00};
    end else if (sum2 == '0) begin
      res_c = {zsign2, {(W-1){1'b0}}};
    end else if (exp_n <= 0) begin
      res_c   = {sign2, {(W-1){1'b0}}};
      flags_c = 3'b001;
    end else if (exp_r >= (1 << EXP_W) - 1) begin
      res_c   = {sign2, EXP_ONES, {MAN_W{1'b0}}};
      flags_c = 3'b011;
    end else begin
      res_c   = {sign2, exp_r[EXP_W-1:0], frac};
      flags_c = {2'b00, inexact};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (!stall) begin
      out_valid <= v2;
      result    <= res_c;
      flags     <= flags_c;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
module tb_fp_addsub_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 1 + EXP_W + MAN_W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         op = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic [2:0]   flags;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_out    = 0;
  int          lat;
  int          n_before;
  logic        check_lat = 1'b1;
  logic [34:0] exp_q[$];
  int          lat_q[$];

  logic [31:0] st_a [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] st_e [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                            32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

  fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", tag, got, expv);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic opv,
                      input logic [34:0] ev);
    int   tries;
    logic done;
    tries = 0;
    done  = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    a  = av;
    b  = bv;
    op = opv;
    while (!done) begin
      #4;
      if (in_ready) begin
        exp_q.push_back(ev);
        lat_q.push_back(cyc);
        done = 1'b1;
      end else if (tries >= 50) begin
        check("accept_timeout", 64'(in_ready), 64'd1);
        done = 1'b1;
      end else begin
        tries++;
      end
      @(posedge clk);
      #1;
      if (!done) @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && out_valid) begin
        if (!out_ready) begin
          check("stall_in_ready", 64'(in_ready), 64'd0);
          if (exp_q.size() > 0) check("stall_hold", 64'({flags, result}), 64'(exp_q[0]));
        end else begin
          n_out++;
          check("queue_nonempty", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) check("result", 64'({flags, result}), 64'(exp_q.pop_front()));
          if (lat_q.size() > 0) begin
            lat = cyc - lat_q.pop_front();
            if (check_lat) check("latency", 64'(lat), 64'd3);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, streamed back to back; expected = {flags, result}.
    send(32'h3F800000, 32'h40000000, 1'b0, {3'b000, 32'h40400000}); // 1+2
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {3'b011, 32'h7F800000}); // overflow
    send(32'h3F800000, 32'h3F800000, 1'b1, {3'b000, 32'h00000000}); // 1-1 = +0
    send(32'h7F800000, 32'h7F800000, 1'b1, {3'b100, 32'h7FC00000}); // inf-inf
    send(32'hFF800000, 32'hFF800000, 1'b0, {3'b000, 32'hFF800000}); // -inf + -inf
    send(32'h3F800000, 32'h33800000, 1'b0, {3'b001, 32'h3F800000}); // tie to even
    send(32'h3F800001, 32'h33800000, 1'b0, {3'b001, 32'h3F800002}); // tie, round up
    send(32'h40400000, 32'h3F800000, 1'b1, {3'b000, 32'h40000000}); // 3-1
    send(32'h3F800000, 32'h40000000, 1'b1, {3'b000, 32'hBF800000}); // 1-2
    send(32'h7F800000, 32'h3F800000, 1'b0, {3'b000, 32'h7F800000}); // inf+1
    send(32'h3F800000, 32'h7F800000, 1'b1, {3'b000, 32'hFF800000}); // 1-inf
    send(32'h7FC00001, 32'h3F800000, 1'b0, {3'b000, 32'h7FC00000}); // qNaN
    send(32'h7F800001, 32'h3F800000, 1'b0, {3'b100, 32'h7FC00000}); // sNaN
    send(32'h80000000, 32'h80000000, 1'b0, {3'b000, 32'h80000000}); // -0 + -0
    send(32'h80000000, 32'h00000000, 1'b1, {3'b000, 32'h80000000}); // -0 - +0
    send(32'h00000001, 32'h3F800000, 1'b0, {3'b000, 32'h3F800000}); // denormal in
    send(32'h00800001, 32'h00800000, 1'b1, {3'b001, 32'h00000000}); // underflow flush
    send(32'h3F800000, 32'h00800000, 1'b0, {3'b001, 32'h3F800000}); // sticky only
    send(32'h3F800000, 32'h33800000, 1'b1, {3'b000, 32'h3F7FFFFF}); // exact borrow
    send(32'h3F800000, 32'h33000000, 1'b1, {3'b001, 32'h3F800000}); // borrow, round up
    drain();

    // Eight back-to-back beats with out_ready low for four cycles mid-stream.
    check_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(st_a[i], 32'h3F800000, 1'b0, {3'b000, st_e[i]});
      end
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    check_lat = 1'b1;

    // Reset pulse with three beats in flight.
    send(32'h3F800000, 32'h3F800000, 1'b0, {3'b000, 32'h40000000});
    send(32'h40000000, 32'h3F800000, 1'b0, {3'b000, 32'h40400000});
    send(32'h40400000, 32'h3F800000, 1'b0, {3'b000, 32'h40800000});
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    n_before = n_out;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    check("async_rst_result", 64'({flags, result}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("flushed_beats", 64'(n_out - n_before), 64'd0);

    // First beat after release still takes three cycles.
    send(32'h40000000, 32'h40000000, 1'b0, {3'b000, 32'h40800000});
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
